matrix_scan_gen2: RTL

MATRIX_SCAN_GEN2 -- requirements
Module: matrix_scan_gen2

---
 rtl/matrix_scan_gen2.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/matrix_scan_gen2.sv
// matrix_scan_gen2: row-multiplexed LED matrix driver with a debounced button stepping the pattern index.
// Define MATRIX_AUTO_SCROLL_EN to compile in automatic stepping every AUTO_FRAMES frames while auto_en is high.
module matrix_scan_gen2 #(
    parameter int unsigned ROWS        = 8,
    parameter int unsigned COLS        = 8,
    parameter int unsigned ROW_CYC     = 50000,
    parameter int unsigned BLANK_CYC   = 500,
    parameter int unsigned DEBOUNCE    = 500000,
    parameter int unsigned AUTO_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    btn,
    input  logic                    switch,
    input  logic                    auto_en,
    output logic [ROWS-1:0]         row,
    output logic [COLS-1:0]         column,
    output logic [$clog2(COLS)-1:0] index,
    output logic                    frame_tick
);
    localparam int unsigned IW   = $clog2(COLS);
    localparam int unsigned RW   = $clog2(ROWS);
    localparam int unsigned CMAX = (ROW_CYC > BLANK_CYC) ? ROW_CYC : BLANK_CYC;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned DW   = $clog2(DEBOUNCE);
    localparam int unsigned AW   = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

    localparam logic [ROWS-1:0] ROW_ONE = {{(ROWS-1){1'b0}}, 1'b1};
    localparam logic [COLS-1:0] COL_ONE = {{(COLS-1){1'b0}}, 1'b1};

    typedef enum logic {LIT = 1'b0, BLANK = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [ROWS-1:0] row_q, row_d;
    logic [COLS-1:0] column_q, column_d;
    logic          frame_tick_q, frame_tick_d;
    logic [IW-1:0] index_q, index_d;
    logic [IW-1:0] pend_q, pend_d;
    logic [IW-1:0] col_sel_c;

    logic          sync1_q, sync2_q, level_q, step_q;
    logic [DW-1:0] db_cnt_q;
    logic          level_flip_c;
    logic          auto_step_c;

    // Synchroniser, stable-level filter and rising-edge step pulse
    assign level_flip_c = (sync2_q != level_q) && (db_cnt_q == DW'(DEBOUNCE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            step_q   <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            step_q  <= level_flip_c && sync2_q;
            if (level_flip_c) begin
                level_q <= sync2_q;
            end
            if ((sync2_q == level_q) || level_flip_c) begin
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DW'(1);
            end
        end
    end

`ifdef MATRIX_AUTO_SCROLL_EN
    logic [AW-1:0] auto_cnt_q, auto_cnt_d;

    // Frame counter for automatic stepping; dropping auto_en restarts the count
    always_comb begin
        auto_step_c = frame_tick_q && auto_en && (auto_cnt_q == AW'(AUTO_FRAMES - 1));
        auto_cnt_d  = auto_cnt_q;
        if (!auto_en) begin
            auto_cnt_d = '0;
        end else if (frame_tick_q) begin
            auto_cnt_d = auto_step_c ? '0 : auto_cnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end
`else
    logic auto_en_unused;
    assign auto_en_unused = auto_en;
    assign auto_step_c    = 1'b0;
`endif

    // Pending index; a manual step masks a coincident automatic one
    always_comb begin
        pend_d = pend_q;
        if (step_q || auto_step_c) begin
            if (switch) begin
                pend_d = (pend_q == IW'(COLS - 1)) ? '0 : pend_q + IW'(1);
            end else begin
                pend_d = (pend_q == '0) ? IW'(COLS - 1) : pend_q - IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= LIT;
            rcnt_q       <= '0;
            cyc_q        <= '0;
            row_q        <= '1;
            column_q     <= '0;
            frame_tick_q <= 1'b0;
            index_q      <= '0;
            pend_q       <= '0;
        end else begin
            state_q      <= state_d;
            rcnt_q       <= rcnt_d;
            cyc_q        <= cyc_d;
            row_q        <= row_d;
            column_q     <= column_d;
            frame_tick_q <= frame_tick_d;
            index_q      <= index_d;
            pend_q       <= pend_d;
        end
    end

    // cyc_q counts cycles already spent in the phase, so the reset cycle is not part of row 0
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        cyc_d   = cyc_q + CW'(1);
        case (state_q)
            LIT: begin
                if (cyc_q == CW'(ROW_CYC)) begin
                    state_d = BLANK;
                    cyc_d   = CW'(1);
                end
            end
            BLANK: begin
                if (cyc_q == CW'(BLANK_CYC)) begin
                    state_d = LIT;
                    cyc_d   = CW'(1);
                    rcnt_d  = (rcnt_q == RW'(ROWS - 1)) ? '0 : rcnt_q + RW'(1);
                end
            end
            default: begin
                state_d = LIT;
            end
        endcase
    end

    // Output values for the coming cycle; the index only swaps as a new frame starts
    always_comb begin
        row_d        = '1;
        column_d     = '0;
        frame_tick_d = (state_d == BLANK) && (rcnt_d == RW'(ROWS - 1)) && (cyc_d == CW'(BLANK_CYC));
        index_d      = frame_tick_q ? pend_d : index_q;
        col_sel_c    = IW'((32'(rcnt_d) + 32'(index_d)) % COLS);
        if (state_d == LIT) begin
            row_d    = ~(ROW_ONE << rcnt_d);
            column_d = COL_ONE << col_sel_c;
        end
    end

    assign row        = row_q;
    assign column     = column_q;
    assign index      = index_q;
    assign frame_tick = frame_tick_q;

endmodule
